// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types and defaults for the load/store unit and the
//                data-memory model (state encoding, word width, sizes).
//  Revision    : 1.0  initial release
// ============================================================================
package lsu_pkg;

    localparam int WORD_W      = 32;
    localparam int DEF_DEPTH   = 40;
    localparam int DEF_ADDR_W  = 6;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } state_t;

    // True when a word index addresses an existing memory word.
    function automatic logic in_bounds(input logic [WORD_W-1:0] idx,
                                       input logic [WORD_W-1:0] depth);
        return idx < depth;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_if
//  Description : EX-stage offer, data-memory request/ack and writeback
//                signals of the load/store unit. The master modport is the
//                unit itself; the slave modport is its environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface load_store_unit_if
    import lsu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    // EX-stage side
    logic              in_valid;
    logic              in_ready;
    logic              in_memread;
    logic              in_memwrite;
    logic              in_memtoreg;
    logic [WORD_W-1:0] in_aluresult;
    logic [WORD_W-1:0] in_valor2;
    // Data-memory side
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [WORD_W-1:0] mem_rdata;
    // Writeback side
    logic              wb_valid;
    logic [WORD_W-1:0] wb_data;
    logic              fault;

    modport master (
        input  in_valid, in_memread, in_memwrite, in_memtoreg,
               in_aluresult, in_valor2, mem_ack, mem_rdata,
        output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
               wb_valid, wb_data, fault
    );

    modport slave (
        output in_valid, in_memread, in_memwrite, in_memtoreg,
               in_aluresult, in_valor2, mem_ack, mem_rdata,
        input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
               wb_valid, wb_data, fault
    );

endinterface
`default_nettype wire

// File: rtl/lsu_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_timeout_counter
//  Description : 8-bit saturating wait counter for the memory acknowledge.
//                o_expired is high in the waiting cycle whose count step
//                would reach TIMEOUT, so the caller can abort on that edge.
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_timeout_counter #(
    parameter int TIMEOUT = 15
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_expired
);

    localparam logic [7:0] c_LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] r_count;

    // Count unacknowledged request cycles, saturating at the 8-bit maximum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_enable && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_expired = i_enable && (r_count >= c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Data-memory initiator between EX and register writeback.
//                Accepts one operation at a time, runs an optional write
//                and an optional read transaction, bounds-checks the word
//                index and aborts with a fault pulse on an ack timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  wire logic         clk,
    input  wire logic         reset,
    load_store_unit_if.master bus
);

    localparam logic [WORD_W-1:0] c_DEPTH = WORD_W'(DEPTH);

    state_t            r_state;
    state_t            w_next;
    logic              r_gap;      // idle request cycle between write and read
    logic              r_rd;       // operation also needs a read
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic [WORD_W-1:0] r_alu;
    logic [WORD_W-1:0] r_wb_data;

    logic w_accept;
    logic w_is_wr;
    logic w_is_rd;
    logic w_oob;
    logic w_req;
    logic w_enable;
    logic w_clear;
    logic w_expired;

    assign w_accept = bus.in_valid && (r_state == IDLE);
    assign w_is_wr  = bus.in_memwrite;
    assign w_is_rd  = bus.in_memread && bus.in_memtoreg;
    assign w_oob    = !in_bounds(bus.in_aluresult, c_DEPTH);
    // The read that follows a write waits one cycle so mem_req visibly drops.
    assign w_req    = (r_state == WRITE) || ((r_state == READ) && !r_gap);
    assign w_enable = w_req && !bus.mem_ack;
    // Restart the wait count whenever a new transaction state is entered.
    assign w_clear  = (w_next != r_state) && ((w_next == WRITE) || (w_next == READ));

    lsu_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_clear),
        .i_enable  (w_enable),
        .o_expired (w_expired)
    );

    // Next-state decode; an ack in the expiring cycle still completes normally.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if ((w_is_wr || w_is_rd) && w_oob) begin
                        w_next = FAULT;
                    end else if (w_is_wr) begin
                        w_next = WRITE;
                    end else if (w_is_rd) begin
                        w_next = READ;
                    end else begin
                        w_next = DONE;
                    end
                end
            end
            WRITE: begin
                if (bus.mem_ack) begin
                    w_next = r_rd ? READ : DONE;
                end else if (w_expired) begin
                    w_next = FAULT;
                end
            end
            READ: begin
                if (!r_gap) begin
                    if (bus.mem_ack) begin
                        w_next = DONE;
                    end else if (w_expired) begin
                        w_next = FAULT;
                    end
                end
            end
            DONE:    w_next = IDLE;
            FAULT:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register and write-to-read gap flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_gap   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_gap   <= (r_state == WRITE) && (w_next == READ);
        end
    end

    // Capture the whole operation in the accepting cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_alu   <= '0;
        end else if (w_accept) begin
            r_rd    <= w_is_rd;
            r_addr  <= bus.in_aluresult[ADDR_W-1:0];
            r_wdata <= bus.in_valor2;
            r_alu   <= bus.in_aluresult;
        end
    end

    // Writeback value changes only on the edge that starts a wb_valid pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_data <= '0;
        end else if (w_next == FAULT) begin
            r_wb_data <= '0;
        end else if (w_next == DONE) begin
            if (r_state == READ) begin
                r_wb_data <= bus.mem_rdata;
            end else if (r_state == IDLE) begin
                r_wb_data <= bus.in_aluresult;
            end else begin
                r_wb_data <= r_alu;
            end
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.mem_req   = w_req;
    assign bus.mem_we    = (r_state == WRITE);
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.wb_valid  = (r_state == DONE) || (r_state == FAULT);
    assign bus.wb_data   = r_wb_data;
    assign bus.fault     = (r_state == FAULT);

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Self-checking bench for load_store_unit: memory responder
//                with programmable ack delay, operation-level reference
//                model with a writeback queue and a transaction queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    localparam int DEPTH   = 40;
    localparam int ADDR_W  = 6;
    localparam int TIMEOUT = 15;

    typedef struct {
        logic [31:0] data;
        logic        flt;
        int          lat;
        int          acc;
    } wb_t;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
    } tx_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

    load_store_unit #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mem_arr [DEPTH];
    logic [31:0] shadow  [DEPTH];
    int          lat      = 1;
    bit          noack    = 1'b0;
    bit          late_ack = 1'b0;
    int          rcnt     = 0;
    wb_t         wbq [$];
    tx_t         txq [$];
    bit          busy     = 1'b0;
    logic [31:0] last_wb  = 32'd0;
    int          run      = 0;
    int          cyc      = 0;
    bit          mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: acks in the request cycle numbered lat+1, never when noack.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            if (late_ack) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = $urandom;
                late_ack      = 1'b0;
                rcnt          = 0;
            end else if (bus.mem_ack) begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = $urandom;
                rcnt          = 0;
            end else if (bus.mem_req && !noack) begin
                rcnt++;
                if (rcnt > lat) begin
                    bus.mem_ack = 1'b1;
                    if (bus.mem_we) mem_arr[bus.mem_addr] = bus.mem_wdata;
                    else            bus.mem_rdata = mem_arr[bus.mem_addr];
                end
            end else begin
                rcnt          = 0;
                bus.mem_rdata = $urandom;
            end
        end
    end

    // Reference model: what one accepted operation must produce.
    task automatic model_accept();
        logic [31:0] a;
        logic        wr, rd, memop, oob, wto;
        wb_t         e;
        a     = bus.in_aluresult;
        wr    = bus.in_memwrite;
        rd    = bus.in_memread && bus.in_memtoreg;
        memop = wr || rd;
        oob   = (a >= 32'(DEPTH));
        wto   = noack || ((lat + 1) > TIMEOUT);
        e.acc = cyc;
        if (memop && oob) begin
            e.data = 32'd0; e.flt = 1'b1; e.lat = 1;
        end else if (memop && wto) begin
            txq.push_back('{we: wr, addr: a[ADDR_W-1:0], wdata: bus.in_valor2});
            e.data = 32'd0; e.flt = 1'b1; e.lat = TIMEOUT + 1;
        end else begin
            e.flt  = 1'b0;
            e.data = a;
            if (wr) begin
                txq.push_back('{we: 1'b1, addr: a[ADDR_W-1:0], wdata: bus.in_valor2});
                shadow[a] = bus.in_valor2;
            end
            if (rd) begin
                txq.push_back('{we: 1'b0, addr: a[ADDR_W-1:0], wdata: 32'd0});
                e.data = shadow[a];
            end
            e.lat = !memop ? 1 : ((wr && rd) ? -1 : lat + 2);
        end
        wbq.push_back(e);
        busy = 1'b1;
    endtask

    // One compare step per cycle, sampled at the falling edge.
    task automatic monitor_step();
        tx_t t;
        wb_t e;
        check("in_ready", 32'(bus.in_ready), 32'(!busy));
        if (bus.mem_req) begin
            n_checks++;
            if (txq.size() == 0) begin
                n_fail++;
                $display("FAIL mem_req_unexpected: got mem_req=1 addr=%0d required no request at %0t", bus.mem_addr, $time);
            end else begin
                t = txq[0];
                check("mem_we", 32'(bus.mem_we), 32'(t.we));
                check("mem_addr", 32'(bus.mem_addr), 32'(t.addr));
                if (t.we) check("mem_wdata", bus.mem_wdata, t.wdata);
            end
            if (bus.mem_ack) begin
                if (txq.size() != 0) void'(txq.pop_front());
                run = 0;
            end else begin
                run++;
            end
        end else if (run > 0) begin
            check("req_cycles_before_timeout", run, TIMEOUT);
            if (txq.size() != 0) void'(txq.pop_front());
            run = 0;
        end
        if (bus.wb_valid) begin
            n_checks++;
            if (wbq.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got wb_valid=1 data=0x%08h required no writeback at %0t", bus.wb_data, $time);
            end else begin
                e = wbq.pop_front();
                check("wb_data", bus.wb_data, e.data);
                check("wb_fault", 32'(bus.fault), 32'(e.flt));
                if (e.lat >= 0) check("wb_latency", cyc - e.acc, e.lat);
            end
            last_wb = bus.wb_data;
            busy    = 1'b0;
        end else begin
            check("fault_without_wb", 32'(bus.fault), 32'd0);
            check("wb_data_held", bus.wb_data, last_wb);
        end
        if (bus.in_valid && bus.in_ready) model_accept();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) monitor_step();
        end
    end

    // Offer one operation, wait for its writeback and pin it to literal values.
    task automatic do_op(input logic w, input logic r, input logic t,
                         input logic [31:0] a, input logic [31:0] v,
                         input logic [31:0] exp_d, input logic exp_f, input int exp_lat);
        int g;
        bit got;
        @(posedge clk);
        #1;
        bus.in_memwrite  = w;
        bus.in_memread   = r;
        bus.in_memtoreg  = t;
        bus.in_aluresult = a;
        bus.in_valor2    = v;
        bus.in_valid     = 1'b1;
        got = 1'b0;
        g   = 0;
        while (!got && g < 50) begin
            @(negedge clk);
            g++;
            got = bus.in_ready;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL op_accept: got in_ready=0 for 50 cycles required 1");
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid     = 1'b0;
        bus.in_aluresult = $urandom;
        bus.in_valor2    = $urandom;
        got = 1'b0;
        g   = 0;
        while (!got && g < 100) begin
            @(negedge clk);
            g++;
            got = bus.wb_valid;
        end
        check("op_wb_seen", 32'(got), 32'd1);
        if (got) begin
            check("op_wb_data", bus.wb_data, exp_d);
            check("op_fault", 32'(bus.fault), 32'(exp_f));
            if (exp_lat >= 0) check("op_latency", g, exp_lat);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] keep4;
        logic [31:0] keep8;
        int          g;
        reset            = 1'b1;
        bus.in_valid     = 1'b0;
        bus.in_memread   = 1'b0;
        bus.in_memwrite  = 1'b0;
        bus.in_memtoreg  = 1'b0;
        bus.in_aluresult = 32'd0;
        bus.in_valor2    = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_arr[i] = $urandom;
            shadow[i]  = mem_arr[i];
        end
        mem_arr[5] = 32'd128;
        shadow[5]  = 32'd128;
        keep4 = mem_arr[4];
        keep8 = mem_arr[8];
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("rst_wb_data", bus.wb_data, 32'd0);
        check("rst_fault", 32'(bus.fault), 32'd0);
        @(posedge clk);
        #3;
        reset  = 1'b0;
        mon_en = 1'b1;

        lat = 1;
        do_op(1'b0, 1'b0, 1'b0, 32'h1234, 32'h5, 32'h1234, 1'b0, 1);
        do_op(1'b0, 1'b1, 1'b1, 32'd5, 32'h0, 32'd128, 1'b0, 3);
        do_op(1'b1, 1'b0, 1'b0, 32'd10, 32'hDEAD, 32'd10, 1'b0, 3);
        do_op(1'b0, 1'b1, 1'b1, 32'd10, 32'h0, 32'hDEAD, 1'b0, 3);
        do_op(1'b1, 1'b1, 1'b1, 32'd3, 32'd99, 32'd99, 1'b0, -1);
        do_op(1'b0, 1'b1, 1'b0, 32'd7, 32'h0, 32'd7, 1'b0, 1);
        do_op(1'b0, 1'b1, 1'b1, 32'd40, 32'h0, 32'd0, 1'b1, 1);
        do_op(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h77, 32'd0, 1'b1, 1);
        lat = 14;
        do_op(1'b0, 1'b1, 1'b1, 32'd8, 32'h0, keep8, 1'b0, 16);
        lat = 15;
        do_op(1'b0, 1'b1, 1'b1, 32'd8, 32'h0, 32'd0, 1'b1, 16);
        lat   = 1;
        noack = 1'b1;
        do_op(1'b1, 1'b0, 1'b0, 32'd4, 32'd55, 32'd0, 1'b1, 16);
        noack = 1'b0;
        do_op(1'b0, 1'b1, 1'b1, 32'd4, 32'h0, keep4, 1'b0, 3);

        // Asynchronous reset in the middle of a read, then a stray late ack.
        lat = 4;
        @(posedge clk);
        #1;
        bus.in_memwrite  = 1'b0;
        bus.in_memread   = 1'b1;
        bus.in_memtoreg  = 1'b1;
        bus.in_aluresult = 32'd7;
        bus.in_valid     = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #3;
        check("pre_rst_mem_req", 32'(bus.mem_req), 32'd1);
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("async_rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("async_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("async_rst_wb_data", bus.wb_data, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        wbq.delete();
        txq.delete();
        busy     = 1'b0;
        run      = 0;
        last_wb  = 32'd0;
        mon_en   = 1'b1;
        late_ack = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
        repeat (3) @(negedge clk);
        lat = 1;
        do_op(1'b0, 1'b1, 1'b1, 32'd5, 32'h0, 32'd128, 1'b0, 3);

        // Randomized traffic with in_valid also offered while busy.
        for (int ph = 1; ph <= 3; ph++) begin
            lat = ph;
            for (int c = 0; c < 300; c++) begin
                @(posedge clk);
                #1;
                bus.in_valid    = 1'($urandom % 2);
                bus.in_memwrite = (($urandom % 3) == 0);
                bus.in_memread  = 1'($urandom % 2);
                bus.in_memtoreg = (($urandom % 4) != 0);
                case ($urandom % 10)
                    0:       bus.in_aluresult = 32'(DEPTH) + ($urandom % 4);
                    1:       bus.in_aluresult = $urandom;
                    default: bus.in_aluresult = $urandom_range(0, DEPTH - 1);
                endcase
                bus.in_valor2 = $urandom;
            end
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            g = 0;
            while ((busy || txq.size() != 0) && g < 100) begin
                @(negedge clk);
                g++;
            end
            check("drain_idle", 32'(busy || (txq.size() != 0)), 32'd0);
        end

        repeat (3) @(negedge clk);
        check("final_queue_empty", wbq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
